// File: rtl/mips_lsu.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// Define MIPS_LSU_SUBWORD_EN to enable sub-word loads/stores (extension and read-modify-write).
module mips_lsu #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
    localparam logic [31:0] DEPTH_LIMIT = DEPTH_WORDS;

    typedef enum logic [1:0] {IDLE, ACCESS, RMW, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [29:0] word_reg;
    logic [31:0] wdata_reg;
    logic [31:0] buf_reg;
    logic        err_reg;
    logic        req_err;
    logic [31:0] load_data;

    // Request legality is decided from the live request so errors skip the memory entirely.
    always_comb begin
        req_err = ({2'b00, req_addr[31:2]} >= DEPTH_LIMIT);
`ifdef MIPS_LSU_SUBWORD_EN
        case (req_op)
            OP_LW, OP_SW:         if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            OP_LH, OP_LHU, OP_SH: if (req_addr[0]) req_err = 1'b1;
            default: ;
        endcase
`else
        if (req_op != OP_LW && req_op != OP_SW) req_err = 1'b1;
        if (req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

`ifdef MIPS_LSU_SUBWORD_EN
    logic [1:0]  off_reg;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_sel = 8'h00;
        case (off_reg)
            2'd0: byte_sel = buf_reg[31:24];
            2'd1: byte_sel = buf_reg[23:16];
            2'd2: byte_sel = buf_reg[15:8];
            2'd3: byte_sel = buf_reg[7:0];
            default: ;
        endcase
        half_sel = off_reg[1] ? buf_reg[15:0] : buf_reg[31:16];
        load_data = 32'h0;
        case (op_reg)
            OP_LW:  load_data = buf_reg;
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        merged = buf_reg;
        if (op_reg == OP_SB) begin
            case (off_reg)
                2'd0: merged[31:24] = wdata_reg[7:0];
                2'd1: merged[23:16] = wdata_reg[7:0];
                2'd2: merged[15:8]  = wdata_reg[7:0];
                2'd3: merged[7:0]   = wdata_reg[7:0];
                default: ;
            endcase
        end else if (off_reg[1]) begin
            merged[15:0] = wdata_reg[15:0];
        end else begin
            merged[31:16] = wdata_reg[15:0];
        end
    end
`else
    assign load_data = (op_reg == OP_LW) ? buf_reg : 32'h0;
`endif

    always_comb begin
        state_next     = state_reg;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = 32'h0;
        mem_write_data = 32'h0;
        case (state_reg)
            IDLE: begin
                if (req_valid) state_next = req_err ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_address = {2'b00, word_reg};
                if (op_reg == OP_SW) begin
                    mem_write      = 1'b1;
                    mem_write_data = wdata_reg;
                end else begin
                    mem_read = 1'b1;
                end
                state_next = DONE;
`ifdef MIPS_LSU_SUBWORD_EN
                if (op_reg == OP_SH || op_reg == OP_SB) state_next = RMW;
`endif
            end
`ifdef MIPS_LSU_SUBWORD_EN
            RMW: begin
                mem_address    = {2'b00, word_reg};
                mem_write      = 1'b1;
                mem_write_data = merged;
                state_next     = DONE;
            end
`endif
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= 3'd0;
            word_reg  <= 30'd0;
            wdata_reg <= 32'h0;
            buf_reg   <= 32'h0;
            err_reg   <= 1'b0;
`ifdef MIPS_LSU_SUBWORD_EN
            off_reg   <= 2'd0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                op_reg    <= req_op;
                word_reg  <= req_addr[31:2];
                wdata_reg <= req_wdata;
                err_reg   <= req_err;
`ifdef MIPS_LSU_SUBWORD_EN
                off_reg   <= req_addr[1:0];
`endif
            end
            if (state_reg == ACCESS) buf_reg <= mem_read_data;
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign resp_valid = (state_reg == DONE);
    assign resp_error = (state_reg == DONE) && err_reg;
    assign resp_rdata = (state_reg == DONE && !err_reg) ? load_data : 32'h0;
endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed vector table, reset-abort sequences and
// randomized traffic against a byte-array reference memory.
module tb_mips_lsu;
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;
`ifdef MIPS_LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] mem  [0:255];
    logic [7:0]  refb [0:1023];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    mips_lsu #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .busy(busy), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;
    always @(negedge clk) begin
        if (mem_write && mem_address < 32'd256) mem[mem_address[7:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as big-endian bytes; access width and rules straight from the op.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd, output int lat,
                                  output logic [1:0] acc);
        int size;
        bit store;
        bit sgn;
        logic [31:0] v;
        store = (op >= OP_SW);
        case (op)
            OP_LW, OP_SW:         size = 4;
            OP_LH, OP_LHU, OP_SH: size = 2;
            default:              size = 1;
        endcase
        sgn = (op == OP_LH || op == OP_LB);
        err = ((addr >> 2) >= 32'd256) || ((addr % 32'(size)) != 32'd0) || (!SUBWORD && size != 4);
        rd = 32'h0;
        acc = 2'b00;
        lat = 1;
        if (!err && store) begin
            for (int i = 0; i < size; i++) refb[addr + 32'(i)] = 8'(wd >> (8 * (size - 1 - i)));
            lat = (size == 4) ? 2 : 3;
            acc = (size == 4) ? 2'b01 : 2'b11;
        end else if (!err) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = (v << 8) | {24'h0, refb[addr + 32'(i)]};
            if (sgn && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
            lat = 2;
            acc = 2'b10;
        end
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, resp_rdata, 32'h0);
        chk({tag, " resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, " mem_address"}, mem_address, 32'h0);
        chk({tag, " mem_write_data"}, mem_write_data, 32'h0);
    endtask

    task automatic run_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                           input int exp_lat, input logic [1:0] exp_acc);
        int waited = 0;
        int lat = 0;
        logic [1:0] acc = 2'b00;
        @(negedge clk);
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
            if (!busy) break;
            acc = acc | {mem_read, mem_write};
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " error"}, 32'(resp_error), 32'(exp_err));
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " mem strobes"}, 32'(acc), 32'(exp_acc));
        chk({tag, " strobes in done"}, 32'({mem_read, mem_write}), 32'd0);
        $display("txn %s op=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
                 tag, op, addr, wd, resp_error, resp_rdata, lat);
    endtask

    task automatic model_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd);
        logic e;
        logic [31:0] r;
        int l;
        logic [1:0] a;
        model(op, addr, wd, e, r, l, a);
        run_txn(tag, op, addr, wd, e, r, l, a);
    endtask

    // Reset pulse while a store is still in flight (extra = posedges past acceptance).
    task automatic abort_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wd, input int extra);
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (extra) @(posedge clk);
        #1 chk({tag, " write before reset"}, 32'(mem_write), 32'd1);
        #1 reset = 1'b1;
        #1 chk_idle_outputs({tag, " in reset"});
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk({tag, " no response"}, 32'(seen), 32'd0);
        $display("txn %s aborted op=%0d addr=%h", tag, op, addr);
    endtask

    initial begin
        logic e;
        logic [31:0] r;
        int l;
        logic [1:0] a;
        int bad;
        logic [2:0] op;
        logic [31:0] addr;
        int pick;

        for (int w = 0; w < 256; w++) begin
            mem[w] = $urandom;
            for (int b = 0; b < 4; b++) refb[4 * w + b] = 8'(mem[w] >> (8 * (3 - b)));
        end

        #1 chk_idle_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 chk_idle_outputs("after reset");

`ifdef MIPS_LSU_SUBWORD_EN
        vecs.push_back('{OP_SW,  32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_LW,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2});
        vecs.push_back('{OP_SW,  32'h10,  32'h11223344, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_SB,  32'h12,  32'h000000AB, 1'b0, 32'h0,        3});
        vecs.push_back('{OP_LW,  32'h10,  32'h0,        1'b0, 32'h1122AB44, 2});
        vecs.push_back('{OP_SW,  32'h14,  32'h80FF7F01, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_LB,  32'h15,  32'h0,        1'b0, 32'hFFFFFFFF, 2});
        vecs.push_back('{OP_LBU, 32'h15,  32'h0,        1'b0, 32'h000000FF, 2});
        vecs.push_back('{OP_LH,  32'h14,  32'h0,        1'b0, 32'hFFFF80FF, 2});
        vecs.push_back('{OP_LHU, 32'h16,  32'h0,        1'b0, 32'h00007F01, 2});
        vecs.push_back('{OP_LW,  32'h13,  32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_SH,  32'h11,  32'hFFFF,     1'b1, 32'h0,        1});
        vecs.push_back('{OP_LW,  32'h400, 32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_LW,  32'h10,  32'h0,        1'b0, 32'h1122AB44, 2});
        vecs.push_back('{OP_SH,  32'h16,  32'h123455AA, 1'b0, 32'h0,        3});
        vecs.push_back('{OP_LB,  32'h17,  32'h0,        1'b0, 32'hFFFFFFAA, 2});
        vecs.push_back('{OP_LW,  32'h14,  32'h0,        1'b0, 32'h80FF55AA, 2});
        vecs.push_back('{OP_SW,  32'h3FC, 32'h12345678, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_LB,  32'h3FF, 32'h0,        1'b0, 32'h00000078, 2});
        vecs.push_back('{OP_LBU, 32'h400, 32'h0,        1'b1, 32'h0,        1});
`else
        vecs.push_back('{OP_SW,  32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_LW,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2});
        vecs.push_back('{OP_LB,  32'h10,  32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_SB,  32'h12,  32'h000000AB, 1'b1, 32'h0,        1});
        vecs.push_back('{OP_LHU, 32'h14,  32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_LW,  32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2});
        vecs.push_back('{OP_LW,  32'h13,  32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_SW,  32'h12,  32'h55555555, 1'b1, 32'h0,        1});
        vecs.push_back('{OP_LW,  32'h400, 32'h0,        1'b1, 32'h0,        1});
        vecs.push_back('{OP_SW,  32'h3FC, 32'h12345678, 1'b0, 32'h0,        2});
        vecs.push_back('{OP_LW,  32'h3FC, 32'h0,        1'b0, 32'h12345678, 2});
`endif
        foreach (vecs[i]) begin
            model(vecs[i].op, vecs[i].addr, vecs[i].wdata, e, r, l, a);
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                    vecs[i].err, vecs[i].rdata, vecs[i].lat, a);
        end

        abort_txn("abort sw", OP_SW, 32'h10, 32'hCAFEF00D, 0);
        model_txn("after abort sw", OP_LW, 32'h10, 32'h0);
`ifdef MIPS_LSU_SUBWORD_EN
        abort_txn("abort sb", OP_SB, 32'h12, 32'h000000CD, 1);
        model_txn("after abort sb", OP_LW, 32'h10, 32'h0);
`endif
        chk("word4 intact", mem[4], {refb[16], refb[17], refb[18], refb[19]});

        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 15);
            if (pick == 0) addr = $urandom;
            else if (pick < 3) addr = 32'($urandom_range(32'h3F0, 32'h40F));
            else addr = 32'($urandom_range(0, 63));
            model_txn($sformatf("rand%0d", n), op, addr, $urandom);
        end

        bad = 0;
        for (int w = 0; w < 256; w++) begin
            if (mem[w] !== {refb[4 * w], refb[4 * w + 1], refb[4 * w + 2], refb[4 * w + 3]}) bad++;
        end
        chk("final memory words differing", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
